// File: rtl/datapath_seq_pkg.sv
// Shared definitions for datapath_seq: ALU op encoding, FSM state codes and
// the blank 7-segment pattern.
package datapath_seq_pkg;

  typedef enum logic [1:0] {
    OP_ADD = 2'd0,
    OP_SUB = 2'd1,
    OP_AND = 2'd2,
    OP_XOR = 2'd3
  } op_e;

  // State codes double as the led_state output value.
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_EXEC  = 3'd2,
    S_SHIFT = 3'd3,
    S_DONE  = 3'd4
  } state_e;

  // Active-low segments: all ones means every segment is off.
  localparam logic [6:0] SEG_BLANK = 7'h7F;

endpackage

// File: rtl/datapath_seq_hex_to_seg7.sv
// hex_to_seg7: 4-bit value to active-low 7-segment pattern, bit order gfedcba.
module hex_to_seg7 (
  input  logic [3:0] hex_i,
  output logic [6:0] seg_o
);

  // Pure lookup table; a segment is lit when its bit is 0.
  always_comb begin
    seg_o = 7'h7F;
    case (hex_i)
      4'h0: seg_o = 7'h40;
      4'h1: seg_o = 7'h79;
      4'h2: seg_o = 7'h24;
      4'h3: seg_o = 7'h30;
      4'h4: seg_o = 7'h19;
      4'h5: seg_o = 7'h12;
      4'h6: seg_o = 7'h02;
      4'h7: seg_o = 7'h78;
      4'h8: seg_o = 7'h00;
      4'h9: seg_o = 7'h10;
      4'hA: seg_o = 7'h08;
      4'hB: seg_o = 7'h03;
      4'hC: seg_o = 7'h46;
      4'hD: seg_o = 7'h21;
      4'hE: seg_o = 7'h06;
      4'hF: seg_o = 7'h0E;
      default: seg_o = 7'h7F;
    endcase
  end

endmodule

// File: rtl/datapath_seq.sv
// datapath_seq: small register-file / ALU / rotator sequencer.
// start (in IDLE) captures the operands, then LOAD -> EXEC -> SHIFT* -> DONE.
// Optional 7-segment display is built when DATAPATH_SEQ_SEG_EN is defined;
// otherwise seg is held blank.
// Handshake: start is a one-cycle request honoured only while busy=0; done
// pulses for exactly one cycle when result/carry are valid.
module datapath_seq
  import datapath_seq_pkg::*;
#(
  parameter int WIDTH  = 4,
  parameter int NREG   = 3,
  parameter int DIGITS = 6
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic [WIDTH-1:0]           data_in,
  input  logic                       sel_mux,
  input  logic [NREG-1:0]            reg_en,
  input  logic [1:0]                 op,
  input  logic [$clog2(WIDTH)-1:0]   shamt,
  output logic                       busy,
  output logic                       done,
  output logic [WIDTH-1:0]           result,
  output logic                       carry,
  output logic [2:0]                 led_state,
  output logic [7*DIGITS-1:0]        seg
);

  localparam int SHW = $clog2(WIDTH);

  state_e            state_q, state_d;
  logic [WIDTH-1:0]  r_q [NREG];
  logic [WIDTH-1:0]  res_q, sh_q;
  logic              carry_q;
  logic [SHW-1:0]    cnt_q;
  logic [WIDTH-1:0]  cap_data_q;
  logic              cap_sel_q;
  logic [NREG-1:0]   cap_en_q;
  op_e               cap_op_q;
  logic [SHW-1:0]    cap_shamt_q;

  logic [WIDTH-1:0]  alu_res;
  logic              alu_carry;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic; SHIFT ends when the down-counter reaches its last step.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = S_LOAD;
      S_LOAD:  state_d = S_EXEC;
      S_EXEC:  state_d = (cap_shamt_q != '0) ? S_SHIFT : S_DONE;
      S_SHIFT: if (cnt_q == SHW'(1)) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // FSM outputs decoded from the current state.
  always_comb begin
    busy      = (state_q != S_IDLE);
    done      = (state_q == S_DONE);
    led_state = state_q;
  end

  // ALU on R[0], R[1]; the extra MSB is the carry for ADD and borrow for SUB.
  always_comb begin
    alu_res   = '0;
    alu_carry = 1'b0;
    case (cap_op_q)
      OP_ADD:  {alu_carry, alu_res} = {1'b0, r_q[0]} + {1'b0, r_q[1]};
      OP_SUB:  {alu_carry, alu_res} = {1'b0, r_q[0]} - {1'b0, r_q[1]};
      OP_AND:  alu_res = r_q[0] & r_q[1];
      OP_XOR:  alu_res = r_q[0] ^ r_q[1];
      default: alu_res = '0;
    endcase
  end

  // Datapath registers: capture in IDLE, load in LOAD, compute in EXEC,
  // rotate in SHIFT; everything holds otherwise.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < NREG; k++) r_q[k] <= '0;
      res_q       <= '0;
      sh_q        <= '0;
      carry_q     <= 1'b0;
      cnt_q       <= '0;
      cap_data_q  <= '0;
      cap_sel_q   <= 1'b0;
      cap_en_q    <= '0;
      cap_op_q    <= OP_ADD;
      cap_shamt_q <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            cap_data_q  <= data_in;
            cap_sel_q   <= sel_mux;
            cap_en_q    <= reg_en;
            cap_op_q    <= op_e'(op);
            cap_shamt_q <= shamt;
          end
        end
        S_LOAD: begin
          for (int k = 0; k < NREG; k++)
            if (cap_en_q[k]) r_q[k] <= cap_sel_q ? res_q : cap_data_q;
        end
        S_EXEC: begin
          res_q   <= alu_res;
          sh_q    <= alu_res;
          carry_q <= alu_carry;
          cnt_q   <= cap_shamt_q;
        end
        S_SHIFT: begin
          sh_q  <= {sh_q[WIDTH-2:0], sh_q[WIDTH-1]};
          cnt_q <= cnt_q - SHW'(1);
        end
        default: ;
      endcase
    end
  end

  assign result = sh_q;
  assign carry  = carry_q;

`ifdef DATAPATH_SEQ_SEG_EN
  // Digit map: 0 = result, 1 = state code, 2+k = R[k], rest blank.
  for (genvar d = 0; d < DIGITS; d++) begin : g_digit
    if (d == 0) begin : g_res
      hex_to_seg7 u_dec (.hex_i(result[3:0]), .seg_o(seg[7*d +: 7]));
    end else if (d == 1) begin : g_state
      hex_to_seg7 u_dec (.hex_i({1'b0, led_state}), .seg_o(seg[7*d +: 7]));
    end else if (d - 2 < NREG) begin : g_reg
      hex_to_seg7 u_dec (.hex_i(r_q[d-2][3:0]), .seg_o(seg[7*d +: 7]));
    end else begin : g_blank
      assign seg[7*d +: 7] = SEG_BLANK;
    end
  end
`else
  assign seg = {DIGITS{SEG_BLANK}};
`endif

endmodule
